// File: rtl/board_renderer_pkg.sv
// rtl/board_renderer_pkg.sv - Board geometry, cell colours and render region types.
package board_renderer_pkg;

  typedef enum logic [2:0] {
    EMPTY, CYAN, YELLOW, PURPLE, GREEN, RED, BLUE, ORANGE
  } block_color;

  localparam int BOARD_COLS = 10;
  localparam int BOARD_ROWS = 20;

  typedef enum logic [1:0] {OUT, BORDER, INTERIOR} render_region_t;

  // Indexed by block_color; highest index first in the concatenation.
  localparam logic [7:0][23:0] PALETTE = {
    24'hFFA500, 24'h0000FF, 24'hFF0000, 24'h00FF00,
    24'h800080, 24'hFFFF00, 24'h00FFFF, 24'h000000
  };

  function automatic logic [23:0] bevel(input logic [23:0] rgb);
    return {1'b0, rgb[23:17], 1'b0, rgb[15:9], 1'b0, rgb[7:1]};
  endfunction

endpackage

// File: rtl/board_renderer_frame_flasher.sv
// rtl/board_renderer_frame_flasher.sv - Counts vsync falling edges and toggles the blink phase.
module board_renderer_frame_flasher #(
  parameter int FLASH_FRAMES = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic vs_n,
  output logic phase
);

  localparam int CW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

  logic          vs_prev_q;
  logic [CW-1:0] count_q, count_d;
  logic          phase_q, phase_d;
  logic          tick;

  assign tick  = vs_prev_q & ~vs_n;
  assign phase = phase_q;

  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (tick) begin
      if (count_q == CW'(FLASH_FRAMES - 1)) begin
        count_d = '0;
        phase_d = ~phase_q;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      vs_prev_q <= 1'b1;
      count_q   <= '0;
      phase_q   <= 1'b0;
    end else begin
      vs_prev_q <= vs_n;
      count_q   <= count_d;
      phase_q   <= phase_d;
    end
  end

endmodule

// File: rtl/board_renderer.sv
// rtl/board_renderer.sv - Maps the VGA raster onto board cells and produces RGB two cycles later.
module board_renderer
  import board_renderer_pkg::*;
#(
  parameter int X0           = 240,
  parameter int Y0           = 80,
  parameter int CELL_LOG2    = 4,
  parameter int BORDER_PX    = 4,
  parameter int FLASH_FRAMES = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        blank_n,
  input  logic        hs_n,
  input  logic        vs_n,
  input  logic [19:0] flash_rows,
  input  block_color  current_pixel,
  output logic [4:0]  x_coord,
  output logic [4:0]  y_coord,
  output logic [7:0]  Red,
  output logic [7:0]  Green,
  output logic [7:0]  Blue,
  output logic        hs_out_n,
  output logic        vs_out_n,
  output logic        blank_out_n,
  output logic        in_board
);

  localparam logic signed [10:0] X0_S = 11'(X0);
  localparam logic signed [10:0] Y0_S = 11'(Y0);
  localparam logic signed [10:0] W_S  = 11'(BOARD_COLS << CELL_LOG2);
  localparam logic signed [10:0] H_S  = 11'(BOARD_ROWS << CELL_LOG2);
  localparam logic signed [10:0] B_S  = 11'(BORDER_PX);

  logic signed [10:0] dx, dy;
  logic               interior, border_box, cell_edge_d, flash_d;
  logic [4:0]         x_d, y_d;
  render_region_t     region_d;

  logic [4:0]     x_q, y_q;
  render_region_t region_q;
  logic           edge_q, flash_q, blank_q, hs_q, vs_q;

  logic [23:0] rgb_d, rgb_q;
  logic        hs2_q, vs2_q, blank2_q;
  logic        phase;

  assign dx = $signed({1'b0, DrawX}) - X0_S;
  assign dy = $signed({1'b0, DrawY}) - Y0_S;

  assign interior   = (dx >= 11'sd0) && (dx < W_S) && (dy >= 11'sd0) && (dy < H_S);
  assign border_box = (dx >= -B_S) && (dx < W_S + B_S) && (dy >= -B_S) && (dy < H_S + B_S);

  // Addresses clamp to cell (0,0) outside the interior so the store never sees an illegal index.
  assign x_d         = interior ? dx[CELL_LOG2 +: 5] : 5'd0;
  assign y_d         = interior ? dy[CELL_LOG2 +: 5] : 5'd0;
  assign cell_edge_d = interior && ((dx[CELL_LOG2-1:0] == '0) || (dy[CELL_LOG2-1:0] == '0));
  assign flash_d     = flash_rows[y_d];
  assign region_d    = interior ? INTERIOR : (border_box ? BORDER : OUT);

  board_renderer_frame_flasher #(
    .FLASH_FRAMES(FLASH_FRAMES)
  ) u_flash (
    .Clk  (Clk),
    .Reset(Reset),
    .vs_n (vs_n),
    .phase(phase)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      x_q      <= '0;
      y_q      <= '0;
      region_q <= OUT;
      edge_q   <= 1'b0;
      flash_q  <= 1'b0;
      blank_q  <= 1'b0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      region_q <= region_d;
      edge_q   <= cell_edge_d;
      flash_q  <= flash_d;
      blank_q  <= blank_n;
      hs_q     <= hs_n;
      vs_q     <= vs_n;
    end
  end

  // current_pixel already reflects x_q/y_q, so colour select happens in the same cycle.
  always_comb begin
    rgb_d = 24'h000000;
    if (blank_q) begin
      case (region_q)
        BORDER:   rgb_d = 24'h808080;
        INTERIOR: begin
          if (flash_q && phase)
            rgb_d = 24'hFFFFFF;
          else if (current_pixel == EMPTY)
            rgb_d = edge_q ? 24'h202020 : 24'h000000;
          else
            rgb_d = edge_q ? bevel(PALETTE[current_pixel]) : PALETTE[current_pixel];
        end
        default:  rgb_d = 24'h000000;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rgb_q    <= '0;
      hs2_q    <= 1'b1;
      vs2_q    <= 1'b1;
      blank2_q <= 1'b0;
    end else begin
      rgb_q    <= rgb_d;
      hs2_q    <= hs_q;
      vs2_q    <= vs_q;
      blank2_q <= blank_q;
    end
  end

  assign x_coord     = x_q;
  assign y_coord     = y_q;
  assign in_board    = (region_q == INTERIOR);
  assign Red         = rgb_q[23:16];
  assign Green       = rgb_q[15:8];
  assign Blue        = rgb_q[7:0];
  assign hs_out_n    = hs2_q;
  assign vs_out_n    = vs2_q;
  assign blank_out_n = blank2_q;

endmodule
